// File: rtl/dm_resp.sv
// Data-memory responder: one load/store at a time over req/rdy, programmable
// wait states, little-endian lane steering with sign/zero extension on loads.
module dm_resp #(
  parameter int ADDR_W = 13,
  parameter int WAIT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              wr,
  input  logic [2:0]        sel,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       din,
  output logic              rdy,
  output logic [31:0]       dout,
  output logic              err
);

  localparam int DEPTH = 1 << (ADDR_W - 2);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [2:0]        sel_q, sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       din_q, din_d;
  logic              rdy_q, rdy_d;
  logic [31:0]       dout_q, dout_d;
  logic              err_q, err_d;

  logic              accept;
  logic              access;
  logic              bad;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic [31:0]       load_val;
  logic [15:0]       half_v;
  logic [7:0]        byte_v;
  logic [3:0][7:0]   rd_lane;

  // Request decode works entirely from the latched copy of the inputs.
  always_comb begin
    bad      = 1'b0;
    be       = 4'b0000;
    wdata    = din_q;
    load_val = 32'd0;
    half_v   = addr_q[1] ? rd_lane[3:2] : rd_lane[1:0];
    byte_v   = rd_lane[addr_q[1:0]];
    case (sel_q)
      3'd0: begin
        bad      = (addr_q[1:0] != 2'b00);
        be       = 4'b1111;
        load_val = rd_lane;
      end
      3'd1, 3'd2: begin
        bad      = addr_q[0];
        be       = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata    = {din_q[15:0], din_q[15:0]};
        load_val = (sel_q == 3'd2) ? {{16{half_v[15]}}, half_v} : {16'd0, half_v};
      end
      3'd3, 3'd4: begin
        be       = 4'b0001 << addr_q[1:0];
        wdata    = {4{din_q[7:0]}};
        load_val = (sel_q == 3'd4) ? {{24{byte_v[7]}}, byte_v} : {24'd0, byte_v};
      end
      default: bad = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    din_d   = din_q;
    rdy_d   = 1'b0;
    dout_d  = dout_q;
    err_d   = err_q;
    accept  = 1'b0;
    access  = 1'b0;
    case (state_q)
      S_IDLE, S_RESP: begin
        if (req) begin
          accept  = 1'b1;
          wr_d    = wr;
          sel_d   = sel;
          addr_d  = addr;
          din_d   = din;
          cnt_d   = 4'(WAIT);
          state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          access  = 1'b1;
          state_d = S_RESP;
          rdy_d   = 1'b1;
          err_d   = bad;
          dout_d  = (wr_q || bad) ? 32'd0 : load_val;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      sel_q   <= 3'd0;
      addr_q  <= '0;
      din_q   <= 32'd0;
      rdy_q   <= 1'b0;
      dout_q  <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      rdy_q   <= rdy_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
    end
  end

  // One byte-wide RAM per lane. The read is registered at acceptance; nothing
  // else can write between acceptance and the access edge, so it is current.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_byte_q;

    always_ff @(posedge clk) begin
      if (access && wr_q && !bad && be[gi]) begin
        mem[addr_q[ADDR_W-1:2]] <= wdata[8*gi +: 8];
      end
      if (accept) begin
        rd_byte_q <= mem[addr[ADDR_W-1:2]];
      end
    end

    assign rd_lane[gi] = rd_byte_q;
  end

  assign rdy  = rdy_q;
  assign dout = dout_q;
  assign err  = err_q;

endmodule

// File: tb/tb_dm_resp.sv
// Self-checking bench for dm_resp: four instances with WAIT = 0, 1, 3, 5,
// a directed vector table, multi-cycle sequences and a random phase.
module tb_dm_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req_v = 4'b0000;
  logic        wr = 1'b0;
  logic [2:0]  sel = 3'd0;
  logic [12:0] addr = 13'd0;
  logic [31:0] din = 32'd0;
  logic [3:0]  rdy_v;
  logic [3:0]  err_v;
  logic [31:0] dout_v [4];

  int n_chk  = 0;
  int n_fail = 0;
  int n_txn  = 0;

  // reference memory: key = instance*65536 + byte address
  bit [7:0] ref_mem [int];

  always #5 clk = ~clk;

  function automatic int wait_of(input int i);
    return (i == 0) ? 0 : (i == 1) ? 1 : (i == 2) ? 3 : 5;
  endfunction

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    dm_resp #(.ADDR_W(13), .WAIT(wait_of(gi))) u_dut (
      .clk  (clk),
      .rst  (rst),
      .req  (req_v[gi]),
      .wr   (wr),
      .sel  (sel),
      .addr (addr),
      .din  (din),
      .rdy  (rdy_v[gi]),
      .dout (dout_v[gi]),
      .err  (err_v[gi])
    );
  end

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endfunction

  // Behavioural model: size in bytes, alignment by modulo, little-endian bytes.
  function automatic void model(input int inst, input bit w, input bit [2:0] s, input int a,
                                input bit [31:0] d, output bit [31:0] ed, output bit ee);
    int size;
    longint v;
    size = (s == 3'd0) ? 4 : (s <= 3'd2) ? 2 : (s <= 3'd4) ? 1 : 0;
    ed = 32'd0;
    ee = (size == 0) || ((a % size) != 0);
    if (ee) return;
    if (w) begin
      for (int i = 0; i < size; i++) ref_mem[inst*65536 + a + i] = 8'((d >> (8*i)) & 32'hFF);
    end else begin
      v = 0;
      for (int i = 0; i < size; i++) v = v + (longint'(ref_mem[inst*65536 + a + i]) << (8*i));
      if ((s == 3'd2 || s == 3'd4) && v >= (longint'(1) << (8*size - 1)))
        v = v - (longint'(1) << (8*size));
      ed = 32'(v);
    end
  endfunction

  task automatic do_req(input int inst, input bit w, input bit [2:0] s, input bit [12:0] a,
                        input bit [31:0] d, output bit [31:0] got_d, output bit got_e,
                        output int edges);
    bit seen;
    @(negedge clk);
    wr = w; sel = s; addr = a; din = d; req_v[inst] = 1'b1;
    edges = 0; got_d = 32'd0; got_e = 1'b0; seen = 1'b0;
    while (edges < 40 && !seen) begin
      @(posedge clk);
      edges++;
      if (edges == 1) begin
        #1;
        req_v[inst] = 1'b0;
        wr = 1'($urandom); sel = 3'($urandom); addr = 13'($urandom); din = $urandom;
      end
      @(negedge clk);
      if (rdy_v[inst]) begin
        got_d = dout_v[inst]; got_e = err_v[inst]; seen = 1'b1;
      end
    end
    if (!seen) begin
      n_chk++; n_fail++;
      $display("FAIL rdy_timeout inst %0d: no rdy within 40 edges, expected %0d", inst, wait_of(inst) + 2);
      edges = -1;
    end
    @(posedge clk);
    @(negedge clk);
    chk("rdy_width", 32'(rdy_v[inst]), 32'd0);
    n_txn++;
    $display("txn %0d inst %0d wr=%0d sel=%0d addr=0x%03h din=0x%08h -> dout=0x%08h err=%0d edges=%0d",
             n_txn, inst, w, s, a, d, got_d, got_e, edges);
  endtask

  typedef struct {
    int          inst;
    bit          w;
    bit [2:0]    s;
    bit [12:0]   a;
    bit [31:0]   d;
    bit [31:0]   exp_d;
    bit          exp_e;
    int          exp_edges;
  } vec_t;

  vec_t vecs [22];

  initial begin
    bit [31:0] gd, md;
    bit        ge, me;
    int        ed;
    int        pulses, last, consec, cnt_rdy;
    bit        prev_rdy;
    bit [31:0] bb_data [4];

    vecs[0]  = '{1, 1, 3'd0, 13'h010, 32'hDEADBEEF, 32'h00000000, 0, 3};
    vecs[1]  = '{1, 0, 3'd0, 13'h010, 32'h0,        32'hDEADBEEF, 0, 3};
    vecs[2]  = '{1, 1, 3'd0, 13'h020, 32'h00000000, 32'h00000000, 0, 3};
    vecs[3]  = '{1, 1, 3'd3, 13'h022, 32'hFFFFFF80, 32'h00000000, 0, 3};
    vecs[4]  = '{1, 0, 3'd0, 13'h020, 32'h0,        32'h00800000, 0, 3};
    vecs[5]  = '{1, 0, 3'd3, 13'h022, 32'h0,        32'h00000080, 0, 3};
    vecs[6]  = '{1, 0, 3'd4, 13'h022, 32'h0,        32'hFFFFFF80, 0, 3};
    vecs[7]  = '{1, 0, 3'd2, 13'h022, 32'h0,        32'h00000080, 0, 3};
    vecs[8]  = '{1, 1, 3'd0, 13'h021, 32'h55555555, 32'h00000000, 1, 3};
    vecs[9]  = '{1, 0, 3'd0, 13'h020, 32'h0,        32'h00800000, 0, 3};
    vecs[10] = '{1, 0, 3'd6, 13'h020, 32'h0,        32'h00000000, 1, 3};
    vecs[11] = '{0, 1, 3'd0, 13'h100, 32'hCAFEF00D, 32'h00000000, 0, 2};
    vecs[12] = '{0, 0, 3'd0, 13'h100, 32'h0,        32'hCAFEF00D, 0, 2};
    vecs[13] = '{3, 1, 3'd0, 13'h100, 32'h11223344, 32'h00000000, 0, 7};
    vecs[14] = '{3, 0, 3'd2, 13'h102, 32'h0,        32'h00001122, 0, 7};
    vecs[15] = '{3, 0, 3'd4, 13'h103, 32'h0,        32'h00000011, 0, 7};
    vecs[16] = '{3, 1, 3'd1, 13'h102, 32'hABCD8001, 32'h00000000, 0, 7};
    vecs[17] = '{3, 0, 3'd0, 13'h100, 32'h0,        32'h80013344, 0, 7};
    vecs[18] = '{3, 0, 3'd2, 13'h102, 32'h0,        32'hFFFF8001, 0, 7};
    vecs[19] = '{3, 0, 3'd1, 13'h101, 32'h0,        32'h00000000, 1, 7};
    vecs[20] = '{2, 1, 3'd0, 13'h040, 32'hA5A5A5A5, 32'h00000000, 0, 5};
    vecs[21] = '{2, 0, 3'd0, 13'h040, 32'h0,        32'hA5A5A5A5, 0, 5};

    // Reset state, checked while rst is held and no clock edge has intervened.
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("reset_rdy", 32'(rdy_v[i]), 32'd0);
      chk("reset_dout", dout_v[i], 32'd0);
      chk("reset_err", 32'(err_v[i]), 32'd0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[k]) begin
      model(vecs[k].inst, vecs[k].w, vecs[k].s, int'(vecs[k].a), vecs[k].d, md, me);
      do_req(vecs[k].inst, vecs[k].w, vecs[k].s, vecs[k].a, vecs[k].d, gd, ge, ed);
      chk($sformatf("vec%0d_dout", k), gd, vecs[k].exp_d);
      chk($sformatf("vec%0d_err", k), 32'(ge), 32'(vecs[k].exp_e));
      chk($sformatf("vec%0d_edges", k), 32'(ed), 32'(vecs[k].exp_edges));
    end

    // Reset during WAIT of a store: outputs clear at once, store is dropped.
    chk("pre_rst_dout", dout_v[2], 32'hA5A5A5A5);
    @(negedge clk);
    wr = 1'b1; sel = 3'd0; addr = 13'h040; din = 32'h12345678; req_v[2] = 1'b1;
    @(posedge clk);
    #1 req_v[2] = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_rdy", 32'(rdy_v[2]), 32'd0);
    chk("rst_mid_dout", dout_v[2], 32'd0);
    chk("rst_mid_err", 32'(err_v[2]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cnt_rdy = 0;
    repeat (10) begin
      @(negedge clk);
      if (rdy_v[2]) cnt_rdy++;
    end
    chk("rst_mid_no_rdy", 32'(cnt_rdy), 32'd0);
    do_req(2, 1'b0, 3'd0, 13'h040, 32'h0, gd, ge, ed);
    chk("rst_mid_reload", gd, 32'hA5A5A5A5);

    // Back-to-back loads with req held high, WAIT=0.
    for (int k = 0; k < 4; k++) begin
      bb_data[k] = $urandom;
      model(0, 1'b1, 3'd0, 32'h200 + 4*k, bb_data[k], md, me);
      do_req(0, 1'b1, 3'd0, 13'(32'h200 + 4*k), bb_data[k], gd, ge, ed);
    end
    @(negedge clk);
    wr = 1'b0; sel = 3'd0; addr = 13'h200; req_v[0] = 1'b1;
    pulses = 0; last = -10; consec = 0; prev_rdy = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (rdy_v[0] && prev_rdy) consec++;
      prev_rdy = rdy_v[0];
      if (rdy_v[0]) begin
        if (pulses < 4) chk($sformatf("b2b_dout%0d", pulses), dout_v[0], bb_data[pulses]);
        if (pulses > 0) chk("b2b_spacing", 32'(cyc - last), 32'd2);
        last = cyc;
        pulses++;
        if (pulses >= 4) req_v[0] = 1'b0;
        else addr = 13'(32'h200 + 4*pulses);
      end
    end
    req_v[0] = 1'b0;
    chk("b2b_pulses", 32'(pulses), 32'd4);
    chk("b2b_consecutive", 32'(consec), 32'd0);

    // Random phase: prefill a region, then mixed traffic against the model.
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 16; k++) begin
        din = $urandom;
        model(i, 1'b1, 3'd0, 32'h300 + 4*k, din, md, me);
        do_req(i, 1'b1, 3'd0, 13'(32'h300 + 4*k), din, gd, ge, ed);
      end
    end
    for (int t = 0; t < 60; t++) begin
      int        inst;
      bit        w;
      bit [2:0]  s;
      bit [12:0] a;
      bit [31:0] d;
      inst = $urandom_range(3, 0);
      w    = 1'($urandom_range(1, 0));
      s    = 3'($urandom_range(7, 0));
      a    = 13'(32'h300 + $urandom_range(63, 0));
      d    = $urandom;
      model(inst, w, s, int'(a), d, md, me);
      do_req(inst, w, s, a, d, gd, ge, ed);
      chk("rand_dout", gd, md);
      chk("rand_err", 32'(ge), 32'(me));
      chk("rand_edges", 32'(ed), 32'(wait_of(inst) + 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_resp.md
# dm_resp

Data-memory responder for the MIPS core's MEM stage: the memory-side end of the load/store interface. It accepts one load or store request at a time over a req/rdy handshake, inserts a programmable number of wait states, and performs byte/halfword/word lane steering with sign or zero extension on loads. Misaligned or malformed requests complete with an error flag instead of touching memory. It lets the pipeline run against slow memory, with stall logic keyed off `rdy`.

## Interface
- `ADDR_W`, default 13: byte-address width. Storage is 2^(ADDR_W-2) 32-bit words.
- `WAIT`, default 1: wait-state cycles inserted before each access (0–15).
- `clk` input 1: clock. All state changes on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req` input 1: request valid. Sampled only in IDLE or RESP.
- `wr` input 1: 1 = store, 0 = load.
- `sel` input 3: access size. 000 word, 001 half unsigned, 010 half signed, 011 byte unsigned, 100 byte signed; 101–111 reserved.
- `addr` input ADDR_W: byte address.
- `din` input 32: store data, taken from the low bits for half and byte stores.
- `rdy` output 1: one-cycle completion pulse.
- `dout` output 32: load result, valid while `rdy`=1.
- `err` output 1: request rejected, valid while `rdy`=1.

## Operation
- States: IDLE, WAIT, RESP.
- **IDLE/RESP, req=1:** latch `wr`, `sel`, `addr`, `din`; load `cnt`←WAIT; go to WAIT.
- **IDLE, req=0:** stay in IDLE.
- **RESP, req=0:** go to IDLE.
- **WAIT, cnt≠0:** cnt←cnt−1.
- **WAIT, cnt=0:** perform the access on this edge, go to RESP.
- **Access word index:** addr[ADDR_W-1:2].
- **Alignment check:**
  - Word with addr[1:0]≠0 is misaligned.
  - Half with addr[0]≠0 is misaligned.
  - Any reserved `sel` is an error.
  - On error: err←1, dout←0, memory unchanged.
- **Stores (little-endian lanes):**
  - Word writes all 4 bytes.
  - Half writes bytes {addr[1],0} and {addr[1],1} with din[15:0].
  - Byte writes byte addr[1:0] with din[7:0].
  - Other bytes are preserved.
  - Store completion: dout←0, err←0.
- **Loads:**
  - Word returns mem[31:0].
  - Half selects bits [16*addr[1] +: 16].
  - Byte selects bits [8*addr[1:0] +: 8].
  - Signed variants sign-extend to 32 bits; unsigned variants zero-extend.
- **Input capture:** inputs changing after acceptance have no effect. The latched copy is used.
- **Memory contents:** not reset. Reading an unwritten word returns an undefined value; the bench must write before reading.

## Timing
- **Reset values:** state=IDLE, cnt=0, rdy=0, dout=0, err=0. Reset is asynchronous: outputs clear immediately on `rst` rising, independent of `clk`.
- **Reset mid-operation:** a pending store is discarded (memory unchanged), no `rdy` is issued, and the first edge after `rst` deasserts samples in IDLE.
- **Latency:**
  - Request accepted at edge E0.
  - Access performed at E0+WAIT+1.
  - `rdy`/`dout`/`err` high for the cycle following E0+WAIT+1.
  - With WAIT=0: `rdy` in the cycle after E0+1, i.e. 2 edges after acceptance.
- **`rdy` width:** exactly one cycle per accepted request, never back-to-back in consecutive cycles.
- **Throughput:**
  - A `req` sampled in RESP is accepted, giving one access per WAIT+2 cycles.
  - `dout`/`err` hold their values through WAIT of the following request and update only at its access edge.
- **`req` in WAIT:** ignored. The requester must hold `req` until it sees `rdy`. No request is lost when `req` stays high, because the next sample point is RESP.
- **Store then load, same address:** the load returns the new data. The store commits one or more cycles before the load's access edge.
- **`cnt` width:** 4 bits. WAIT values >15 are illegal; no check is made.

## Test plan
- **Word round-trip, WAIT=1:**
  - Store 0xDEADBEEF to 0x010, then load word from 0x010 → dout=0xDEADBEEF, err=0.
  - `rdy` rises 3 edges after each acceptance edge (E0+WAIT+2).
- **Byte lanes:**
  - Store word 0x00000000 to 0x020, store byte din=0x80 to 0x022.
  - Load word → 0x00800000.
  - lbu at 0x022 → 0x00000080.
  - lb at 0x022 → 0xFFFFFF80.
  - lh at 0x022 → 0x00000080.
- **Misalignment:**
  - Store word to 0x021 → err=1, dout=0, `rdy` pulses once.
  - Subsequent load word from 0x020 still returns the prior contents.
  - sel=110 → err=1.
- **Latency sweep:** WAIT=0 and WAIT=5 → `rdy` exactly 2 and 7 edges after acceptance; one-cycle pulse each.
- **Back-to-back:** hold `req`=1 for 4 loads with WAIT=0 → `rdy` pulses every 2 cycles; 4 pulses, no duplicates.
- **Reset mid-store:**
  - Store 0x12345678 to 0x040 with WAIT=3; assert `rst` during WAIT.
  - Outputs go 0 immediately; no `rdy`.
  - A following load from 0x040 returns the pre-store value.
